// File: rtl/pe_row_engine.sv
// pe_row_engine -- PE-side responder for the activation/weight memory controller.
//
// Consumes the controller's element stream, runs a LANES-wide signed MAC over
// the non-zero elements of a row, paces the controller with cnt and the
// row_finish_done_0/1 and row_cal_done pulses, then drains the LANES partial
// sums one lane per beat over a valid/ready port.
//
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   mode               1: serial weight x parallel act, 0: serial act x parallel weight
//   en                 one-cycle start pulse (ignored outside IDLE)
//   parallel_in        LANES packed operands, lane k at [k*DATA_W +: DATA_W]
//   serial_in          scalar operand shared by all lanes
//   act_index/wei_index informational only
//   row_index          current row, latched into psum_tag at drain entry
//   row_val_num        non-zero element count minus 1
//   zero_flag          row has no non-zero elements
//   cnt                element index currently requested
//   row_finish_done_0  pulse: one weight-loop pass complete
//   row_finish_done_1  pulse: all passes complete (cycle before drain)
//   row_cal_done       pulse: row drained, controller may advance
//   psum_valid/ready   drain handshake
//   psum_data/lane/tag drain payload
//
// Build option: define PSUM_SAT_EN to saturate psum_data to the signed OUT_W
// range; otherwise psum_data is the low OUT_W bits of the accumulator.

module pe_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              mac_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed(a) * $signed(b);

  // Accumulator wraps at ACC_W; product is sign-extended before the add.
  always_ff @(posedge clk) begin
    if (!reset)      acc <= '0;
    else if (clr)    acc <= '0;
    else if (mac_en) acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end
endmodule

module pe_row_engine #(
  parameter int DATA_W   = 8,
  parameter int LANES    = 9,
  parameter int IDX_W    = 4,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 16,
  parameter int PASSES   = 5,
  parameter int LAST_ROW = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    en,
  input  logic [LANES*DATA_W-1:0] parallel_in,
  input  logic [DATA_W-1:0]       serial_in,
  input  logic [IDX_W-1:0]        act_index,
  input  logic [IDX_W-1:0]        wei_index,
  input  logic [IDX_W:0]          row_index,
  input  logic [IDX_W-1:0]        row_val_num,
  input  logic                    zero_flag,
  output logic [IDX_W-1:0]        cnt,
  output logic                    row_finish_done_0,
  output logic                    row_finish_done_1,
  output logic                    row_cal_done,
  output logic                    psum_valid,
  input  logic                    psum_ready,
  output logic [OUT_W-1:0]        psum_data,
  output logic [3:0]              psum_lane,
  output logic [IDX_W:0]          psum_tag
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Operands for element k arrive one cycle after cnt=k is driven.
  localparam int STAGES = 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

`ifdef PSUM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  logic [1:0]                     state;
  logic [PASS_W-1:0]              pass_cnt;
  logic                           mode_r;
  logic [STAGES:0]                vld_pipe;
  logic [LANES-1:0][DATA_W-1:0]   par_lanes;
  logic [LANES-1:0][ACC_W-1:0]    acc_all;
  logic                           mac_last, final_pass, beat, last_beat, acc_clr;
  logic                           unused_idx;

  assign unused_idx = ^{act_index, wei_index};
  assign par_lanes  = parallel_in;

  assign mac_last   = (state == S_MAC) && (zero_flag || (cnt == row_val_num));
  assign final_pass = !mode_r || (pass_cnt == PASS_W'(PASSES - 1));
  assign beat       = psum_valid && psum_ready;
  assign last_beat  = beat && (psum_lane == 4'(LANES - 1));
  assign acc_clr    = (state == S_DRAIN) && last_beat;

  // A zero row issues nothing, so the accumulators are untouched.
  assign vld_pipe[0] = (state == S_MAC) && !zero_flag;
  always_ff @(posedge clk) begin
    if (!reset) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pe_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .mac_en (vld_pipe[STAGES]),
      .a      (serial_in),
      .b      (par_lanes[k]),
      .acc    (acc_all[k])
    );
  end

  function automatic logic [OUT_W-1:0] fmt(input logic signed [ACC_W-1:0] a);
`ifdef PSUM_SAT_EN
    if (a > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return OUT_W'(a);
`else
    return OUT_W'(a);
`endif
  endfunction

  // Accumulators are frozen during DRAIN, so a combinational lane mux gives
  // payload that holds under backpressure and already includes the product
  // that lands on the PEND->DRAIN edge.
  assign psum_data = fmt(acc_all[psum_lane]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      pass_cnt          <= '0;
      mode_r            <= 1'b0;
      row_finish_done_0 <= 1'b0;
      row_finish_done_1 <= 1'b0;
      row_cal_done      <= 1'b0;
      psum_valid        <= 1'b0;
      psum_lane         <= '0;
      psum_tag          <= '0;
    end else begin
      row_finish_done_0 <= 1'b0;
      row_finish_done_1 <= 1'b0;
      row_cal_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            mode_r   <= mode;
            cnt      <= '0;
            pass_cnt <= '0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          // Pulses are raised for the PEND cycle so row_finish_done_1 lands
          // exactly one cycle ahead of the drain.
          if (mac_last) begin
            state             <= S_PEND;
            row_finish_done_0 <= 1'b1;
            row_finish_done_1 <= final_pass;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        S_PEND: begin
          if (final_pass) begin
            state      <= S_DRAIN;
            psum_valid <= 1'b1;
            psum_lane  <= '0;
            psum_tag   <= row_index;
          end else begin
            pass_cnt <= pass_cnt + PASS_W'(1);
            cnt      <= '0;
            state    <= S_MAC;
          end
        end
        default: begin
          if (last_beat) begin
            psum_valid   <= 1'b0;
            row_cal_done <= 1'b1;
            cnt          <= '0;
            pass_cnt     <= '0;
            mode_r       <= mode;
            state        <= (psum_tag == (IDX_W+1)'(LAST_ROW)) ? S_IDLE : S_MAC;
          end else if (beat) begin
            psum_lane <= psum_lane + 4'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pe_row_engine.sv
module tb_pe_row_engine;
  localparam int DATA_W = 8;
  localparam int LANES  = 9;
  localparam int IDX_W  = 4;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset = 1'b0;
  logic                    mode = 1'b0;
  logic                    en = 1'b0;
  logic [LANES*DATA_W-1:0] parallel_in;
  logic [DATA_W-1:0]       serial_in;
  logic [IDX_W-1:0]        act_index = '0;
  logic [IDX_W-1:0]        wei_index = '0;
  logic [IDX_W:0]          row_index = '0;
  logic [IDX_W-1:0]        row_val_num = '0;
  logic                    zero_flag = 1'b0;
  logic [IDX_W-1:0]        cnt;
  logic                    row_finish_done_0, row_finish_done_1, row_cal_done;
  logic                    psum_valid;
  logic                    psum_ready = 1'b1;
  logic [OUT_W-1:0]        psum_data;
  logic [3:0]              psum_lane;
  logic [IDX_W:0]          psum_tag;

  pe_row_engine dut (
    .clk(clk), .reset(reset), .mode(mode), .en(en),
    .parallel_in(parallel_in), .serial_in(serial_in),
    .act_index(act_index), .wei_index(wei_index), .row_index(row_index),
    .row_val_num(row_val_num), .zero_flag(zero_flag), .cnt(cnt),
    .row_finish_done_0(row_finish_done_0), .row_finish_done_1(row_finish_done_1),
    .row_cal_done(row_cal_done), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .psum_lane(psum_lane), .psum_tag(psum_tag)
  );

  // Controller model: element data follows cnt by one cycle.
  logic signed [DATA_W-1:0] ser_tab [16];
  logic signed [DATA_W-1:0] par_tab [16][LANES];
  logic [IDX_W-1:0]         cnt_q = '0;
  always @(posedge clk) cnt_q <= cnt;
  assign serial_in = ser_tab[cnt_q];
  always_comb begin
    parallel_in = '0;
    for (int k = 0; k < LANES; k++) parallel_in[k*DATA_W +: DATA_W] = par_tab[cnt_q][k];
  end

  typedef struct packed {
    logic [3:0]       lane;
    logic [OUT_W-1:0] data;
    logic [IDX_W:0]   tag;
  } beat_t;
  beat_t sb[$];

  int npass = 0, ntot = 0;
  int n_rfd0 = 0, n_rfd1 = 0, n_rcd = 0, n_beats = 0, n_hold3 = 0;
  int exp_psum [LANES];

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Backpressure driver: updated just after the edge.
  logic bp_en = 1'b0;
  int   stall = 0;
  always @(posedge clk) begin
    #1;
    if (!bp_en) begin
      psum_ready = 1'b1;
      stall = 0;
    end else if (psum_valid && psum_lane == 4'd3 && stall < 4) begin
      psum_ready = 1'b0;
      stall++;
    end else if (stall >= 4) begin
      psum_ready = ~psum_ready;
    end else begin
      psum_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  logic             exp_rcd = 1'b0, hold_prev = 1'b0;
  logic [3:0]       prev_lane = '0;
  logic [OUT_W-1:0] prev_data = '0;
  beat_t            e;
  always @(negedge clk) begin
    if (reset) begin
      if (exp_rcd) chk("rcd_after_lane8", int'(row_cal_done), 1);
      exp_rcd = 1'b0;
      if (row_finish_done_0) n_rfd0++;
      if (row_finish_done_1) n_rfd1++;
      if (row_cal_done)      n_rcd++;
      if (hold_prev) begin
        chk("hold_lane", int'(psum_lane), int'(prev_lane));
        chk("hold_data", int'($signed(psum_data)), int'($signed(prev_data)));
      end
      hold_prev = psum_valid && !psum_ready;
      if (hold_prev && psum_lane == 4'd3) n_hold3++;
      prev_lane = psum_lane;
      prev_data = psum_data;
      if (psum_valid && psum_ready) begin
        n_beats++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("psum_lane", int'(psum_lane), int'(e.lane));
          chk("psum_data", int'($signed(psum_data)), int'($signed(e.data)));
          chk("psum_tag", int'(psum_tag), int'(e.tag));
        end
        if (psum_lane == 4'd8) exp_rcd = 1'b1;
      end
    end
  end

  task automatic push_row(input int ridx);
    for (int k = 0; k < LANES; k++) sb.push_back({4'(k), 16'(exp_psum[k]), 5'(ridx)});
  endtask

  task automatic pulse_en();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  // c0 is the cycle number of the current negedge (1 = first MAC cycle).
  task automatic wait_rfd1(input string name, input int c0, input int exp_c);
    int c = c0;
    while (!row_finish_done_1 && c < 300) begin @(negedge clk); c++; end
    chk(name, c, exp_c);
    chk({name, "_rfd0_coincide"}, int'(row_finish_done_0), 1);
  endtask

  task automatic wait_rcd(input string name);
    int c = 0;
    while (!row_cal_done && c < 300) begin @(negedge clk); c++; end
    chk(name, int'(row_cal_done), 1);
  endtask

  task automatic check_idle(input string name);
    int r0 = n_rfd0;
    repeat (4) @(negedge clk);
    chk({name, "_cnt"}, int'(cnt), 0);
    chk({name, "_valid"}, int'(psum_valid), 0);
    chk({name, "_no_pass"}, n_rfd0 - r0, 0);
  endtask

  task automatic fill(input int s0, input int s1, input int s2, input int ramp, input int pv);
    for (int i = 0; i < 16; i++) begin
      ser_tab[i] = (i == 0) ? 8'(s0) : (i == 1) ? 8'(s1) : 8'(s2);
      for (int k = 0; k < LANES; k++) par_tab[i][k] = ramp ? 8'(k + 1) : 8'(pv);
    end
  endtask

  int r_rfd0, r_rfd1, r_rcd, r_beats, r_hold;

  initial begin
    fill(0, 0, 0, 0, 0);
    // Reset with an en pulse inside it.
    reset = 1'b0;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_pulses", int'({row_finish_done_0, row_finish_done_1, row_cal_done}), 0);
    chk("rst_valid", int'(psum_valid), 0);
    chk("rst_data", int'(psum_data), 0);
    chk("rst_lane", int'(psum_lane), 0);
    chk("rst_tag", int'(psum_tag), 0);
    reset = 1'b1;
    check_idle("post_rst");

    // Mode 0 single row: serial 3,-2,1 x lane k+1 -> 2*(k+1).
    fill(3, -2, 1, 1, 0);
    for (int k = 0; k < LANES; k++) exp_psum[k] = 2 * (k + 1);
    r_rfd0 = n_rfd0; r_rfd1 = n_rfd1; r_rcd = n_rcd;
    mode = 1'b0; row_val_num = 4'd2; zero_flag = 1'b0; row_index = 5'd13;
    push_row(13);
    pulse_en();
    chk("m0_cnt0", int'(cnt), 0);
    @(negedge clk); chk("m0_cnt1", int'(cnt), 1);
    @(negedge clk); chk("m0_cnt2", int'(cnt), 2);
    wait_rfd1("m0_rfd1_cycle", 3, 4);
    wait_rcd("m0_rcd");
    check_idle("m0_idle");
    chk("m0_n_rfd0", n_rfd0 - r_rfd0, 1);
    chk("m0_n_rfd1", n_rfd1 - r_rfd1, 1);
    chk("m0_n_rcd", n_rcd - r_rcd, 1);

    // Mode 1: five passes of 1*1 -> 5 in every lane.
    fill(1, 1, 1, 0, 1);
    for (int k = 0; k < LANES; k++) exp_psum[k] = 5;
    r_rfd0 = n_rfd0; r_rfd1 = n_rfd1;
    mode = 1'b1; row_val_num = 4'd0; row_index = 5'd13;
    push_row(13);
    pulse_en();
    mode = 1'b0; // mid-row change must be ignored
    wait_rfd1("m1_rfd1_cycle", 1, 10);
    wait_rcd("m1_rcd");
    check_idle("m1_idle");
    chk("m1_n_rfd0", n_rfd0 - r_rfd0, 5);
    chk("m1_n_rfd1", n_rfd1 - r_rfd1, 1);

    // Zero rows 12 then 13, mode 1: 2 cycles per pass, psums stay 0.
    fill(5, 5, 5, 0, 5);
    for (int k = 0; k < LANES; k++) exp_psum[k] = 0;
    r_beats = n_beats; r_rcd = n_rcd;
    mode = 1'b1; zero_flag = 1'b1; row_val_num = 4'd15; row_index = 5'd12;
    push_row(12);
    push_row(13);
    pulse_en();
    wait_rfd1("z12_rfd1_cycle", 1, 10);
    wait_rcd("z12_rcd");
    row_index = 5'd13;
    wait_rfd1("z13_rfd1_cycle", 1, 10);
    wait_rcd("z13_rcd");
    check_idle("z_idle");
    chk("z_beats", n_beats - r_beats, 18);
    chk("z_n_rcd", n_rcd - r_rcd, 2);
    zero_flag = 1'b0;

    // Backpressure: ready low 4 cycles at lane 3, then toggling.
    fill(3, -2, 1, 1, 0);
    for (int k = 0; k < LANES; k++) exp_psum[k] = 2 * (k + 1);
    r_beats = n_beats; r_hold = n_hold3;
    mode = 1'b0; row_val_num = 4'd2; row_index = 5'd13;
    bp_en = 1'b1;
    push_row(13);
    pulse_en();
    wait_rfd1("bp_rfd1_cycle", 1, 4);
    wait_rcd("bp_rcd");
    bp_en = 1'b0;
    check_idle("bp_idle");
    chk("bp_beats", n_beats - r_beats, 9);
    chk("bp_hold3", n_hold3 - r_hold, 4);

    // Saturation / wrap: 3 x 127*127 = 48387.
    fill(127, 127, 127, 0, 127);
`ifdef PSUM_SAT_EN
    for (int k = 0; k < LANES; k++) exp_psum[k] = 32767;
`else
    for (int k = 0; k < LANES; k++) exp_psum[k] = -17149;
`endif
    push_row(13);
    pulse_en();
    wait_rfd1("sat_rfd1_cycle", 1, 4);
    wait_rcd("sat_rcd");
    check_idle("sat_idle");

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
